fifo_pop_stream: RTL and testbench



---
 rtl/fifo_pop_stream.sv | 110 +++++++++++
 tb/tb_fifo_pop_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a FWFT FIFO pop port into a valid/ready stream
// through a 2-entry skid buffer, with enable, flush and a pop counter.
module fifo_pop_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_pop_o,
  input  logic              enable_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  words_popped_o
);

  typedef enum logic [1:0] {
    CNT0 = 2'd0,
    CNT1 = 2'd1,
    CNT2 = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  popped_q;
  logic              ld, rd;

  // Pop depends only on registered occupancy and the FIFO flag,
  // never on out_ready_i.
  assign fifo_pop_o = !reset && !fifo_empty_i && enable_i
                    && (occ_q != CNT2) && !flush_i;

  assign ld = fifo_pop_o;
  assign rd = out_valid_o && out_ready_i && !flush_i;

  assign out_valid_o    = (occ_q != CNT0);
  assign out_data_o     = head_q;
  assign words_popped_o = popped_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      occ_d = CNT0;
    end else begin
      unique case (1'b1)
        (ld && !rd): begin
          case (occ_q)
            CNT0: begin
              head_d = fifo_data_i;
              occ_d  = CNT1;
            end
            CNT1: begin
              tail_d = fifo_data_i;
              occ_d  = CNT2;
            end
            default: ;
          endcase
        end
        (rd && !ld): begin
          if (occ_q == CNT2) begin
            head_d = tail_q;
            occ_d  = CNT1;
          end else begin
            occ_d = CNT0;
          end
        end
        (ld && rd): begin
          head_d = fifo_data_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q    <= CNT0;
      head_q   <= '0;
      tail_q   <= '0;
      popped_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (ld) popped_q <= popped_q + CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_occ_max: assert property (
    @(posedge clk) disable iff (reset)
    occ_q != 2'd3);

  a_pop_empty: assert property (
    @(posedge clk) disable iff (reset)
    fifo_empty_i |-> !fifo_pop_o);

  a_hold: assert property (
    @(posedge clk) disable iff (reset)
    (out_valid_o && !out_ready_i && !flush_i)
      |=> $stable(out_data_o));
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// tb_fifo_pop_stream: table vectors, directed corners and random traffic
// against a queue-based model of the skid buffer and FIFO.
module tb_fifo_pop_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic        ready;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        pop, pop4;
  logic        valid, valid4;
  logic [7:0]  data, data4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  fifo_pop_stream #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_pop_o(pop), .enable_i(enable), .flush_i(flush),
    .out_valid_o(valid), .out_data_o(data),
    .out_ready_i(ready), .words_popped_o(cnt16)
  );

  fifo_pop_stream #(.DATA_W(8), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_pop_o(pop4), .enable_i(enable), .flush_i(flush),
    .out_valid_o(valid4), .out_data_o(data4),
    .out_ready_i(ready), .words_popped_o(cnt4)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  fq[$];
  logic [7:0]  mb[$];
  logic [31:0] m_cnt;
  logic [7:0]  m_head;
  logic        m_pop;

  typedef struct {
    logic        en, fl, rdy;
    logic        pop, vld;
    logic [7:0]  dat;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_and_check(input logic r, en, fl, rdy);
    reset      = r;
    enable     = en;
    flush      = fl;
    ready      = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    m_pop = !r && (fq.size() != 0) && en && (mb.size() < 2) && !fl;
    @(negedge clk);
    chk("pop", {31'd0, pop}, {31'd0, m_pop});
    chk("pop_w4", {31'd0, pop4}, {31'd0, m_pop});
    chk("valid", {31'd0, valid}, {31'd0, mb.size() != 0});
    chk("valid_w4", {31'd0, valid4}, {31'd0, mb.size() != 0});
    chk("data", {24'd0, data}, {24'd0, m_head});
    chk("cnt", {16'd0, cnt16}, {16'd0, m_cnt[15:0]});
    chk("cnt_w4", {28'd0, cnt4}, {28'd0, m_cnt[3:0]});
  endtask

  task automatic advance();
    logic [7:0] w;
    w = (fq.size() == 0) ? 8'h00 : fq[0];
    @(posedge clk);
    if (reset) begin
      mb.delete();
      m_cnt  = 0;
      m_head = 8'h00;
    end else begin
      if (m_pop) m_cnt = m_cnt + 1;
      if (flush) begin
        mb.delete();
      end else begin
        if (mb.size() != 0 && ready) void'(mb.pop_front());
        if (m_pop) mb.push_back(w);
      end
      if (mb.size() != 0) m_head = mb[0];
    end
    if (m_pop) void'(fq.pop_front());
    #1;
  endtask

  task automatic cyc(input logic r, en, fl, rdy);
    drive_and_check(r, en, fl, rdy);
    advance();
  endtask

  task automatic do_reset();
    fq.delete();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pops, first_pop, first_vld;
    logic [7:0] got[$];

    reset = 1'b1; enable = 1'b0; flush = 1'b0; ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00;
    mb.delete(); m_cnt = 0; m_head = 8'h00; m_pop = 1'b0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // enable gating, backpressure and drain, words A0..A3
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 16'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 16'd2};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 16'd3};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 16'd4};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 16'd4};
    fq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 12; i++) begin
      drive_and_check(1'b0, tbl[i].en, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("tbl%0d_pop", i), {31'd0, pop}, {31'd0, tbl[i].pop});
      chk($sformatf("tbl%0d_vld", i), {31'd0, valid}, {31'd0, tbl[i].vld});
      chk($sformatf("tbl%0d_dat", i), {24'd0, data}, {24'd0, tbl[i].dat});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, cnt16}, {16'd0, tbl[i].cnt});
      advance();
    end

    // continuous flow 0x01..0x10
    do_reset();
    for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
    first_pop = -1; first_vld = -1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      drive_and_check(1'b0, 1'b1, 1'b0, 1'b1);
      if (pop && first_pop < 0) first_pop = c;
      if (valid && first_vld < 0) first_vld = c;
      if (valid && ready) got.push_back(data);
      advance();
    end
    chk("flow_n", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++)
      chk($sformatf("flow_w%0d", i), {24'd0, got[i]}, i + 1);
    chk("flow_lat", first_vld - first_pop, 1);
    chk("flow_cnt", {16'd0, cnt16}, 16);

    // flush with A1,A2 buffered
    do_reset();
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    drive_and_check(1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_nopop", {31'd0, pop}, 0);
    advance();
    drive_and_check(1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_vld0", {31'd0, valid}, 0);
    advance();
    drive_and_check(1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_next", {23'd0, valid, data}, {23'd0, 1'b1, 8'hA3});
    advance();

    // counter wrap on the CNT_W=4 instance
    do_reset();
    for (int i = 0; i < 17; i++) fq.push_back(8'($urandom));
    pops = 0;
    for (int c = 0; c < 40 && pops < 17; c++) begin
      drive_and_check(1'b0, 1'b1, 1'b0, 1'b1);
      advance();
      if (m_pop) begin
        pops++;
        if (pops == 15) chk("wrap15", {28'd0, cnt4}, 15);
        if (pops == 16) chk("wrap16", {28'd0, cnt4}, 0);
        if (pops == 17) chk("wrap17", {28'd0, cnt4}, 1);
      end
    end
    chk("wrap_pops", pops, 17);

    // reset mid-stream
    do_reset();
    fq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    drive_and_check(1'b1, 1'b1, 1'b0, 1'b0);
    advance();
    drive_and_check(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_vld", {31'd0, valid}, 0);
    chk("rst_pop", {31'd0, pop}, 0);
    chk("rst_cnt", {16'd0, cnt16}, 0);
    advance();
    drive_and_check(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_restart_pop", {31'd0, pop}, 1);
    advance();
    drive_and_check(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_restart", {23'd0, valid, data}, {23'd0, 1'b1, 8'hB2});
    advance();

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if (fq.size() < 8 && $urandom_range(1, 0) == 1)
        fq.push_back(8'($urandom));
      cyc($urandom_range(60, 0) == 0,
          $urandom_range(3, 0) != 0,
          $urandom_range(15, 0) == 0,
          $urandom_range(2, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
